commit_stream_checker: RTL and testbench

//  Synthesizable lockstep retirement checker for the multi-cycle RISC-V core; successor to the sim-only compare loop.

---
 rtl/commit_stream_checker.sv | 141 ++++++++++++++
 tb/tb_commit_stream_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_stream_checker.sv
// Lockstep retirement checker: buffers CPU commit records in a FIFO, pops them against a
// golden stream, captures the first divergence, keeps counters and runs the finish/done handshake.
module commit_stream_checker #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    REG_IDX_W   = 5,
  parameter int                    FIFO_DEPTH  = 8,
  parameter int                    CNT_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] END_PC      = 'h58
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           cpu_commit_i,
  input  logic [ADDR_WIDTH-1:0]          cpu_pc_i,
  input  logic [INSTR_WIDTH-1:0]         cpu_instr_i,
  input  logic                           cpu_rd_we_i,
  input  logic [REG_IDX_W-1:0]           cpu_rd_i,
  input  logic [DATA_WIDTH-1:0]          cpu_rd_data_i,
  input  logic                           gold_valid_i,
  input  logic [ADDR_WIDTH-1:0]          gold_pc_i,
  input  logic [INSTR_WIDTH-1:0]         gold_instr_i,
  input  logic                           gold_rd_we_i,
  input  logic [REG_IDX_W-1:0]           gold_rd_i,
  input  logic [DATA_WIDTH-1:0]          gold_rd_data_i,
  output logic                           gold_ready_o,
  output logic                           finish_o,
  input  logic                           mem_done_i,
  output logic                           done_o,
  output logic                           error_o,
  output logic                           overflow_o,
  output logic [ADDR_WIDTH-1:0]          err_pc_o,
  output logic [3:0]                     err_mask_o,
  output logic [CNT_WIDTH-1:0]           cycles_o,
  output logic [CNT_WIDTH-1:0]           commits_o,
  output logic [CNT_WIDTH-1:0]           mismatches_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o,
  output logic [1:0]                     state_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   rd_we;
    logic [REG_IDX_W-1:0]   rd;
    logic [DATA_WIDTH-1:0]  rd_data;
  } rec_t;

  state_t           state, state_nxt;
  rec_t             mem [FIFO_DEPTH];
  rec_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] count;
  logic             full, empty, push_req, push, pop, drop, end_hit;
  logic [3:0]       mask;

  // Handshake: a golden record is consumed in any cycle where gold_valid_i and
  // gold_ready_o are both high; gold_ready_o never depends on gold_valid_i.
  assign empty        = (count == '0);
  assign full         = (count == OCC_W'(FIFO_DEPTH));
  assign gold_ready_o = (state == S_RUN) && !empty;
  assign pop          = gold_valid_i && gold_ready_o;
  assign push_req     = cpu_commit_i && (state == S_RUN);
  assign push         = push_req && (!full || pop);
  assign drop         = push_req && full && !pop;
  assign head         = mem[rd_ptr];

  assign mask[0] = head.pc != gold_pc_i;
  assign mask[1] = head.instr != gold_instr_i;
  assign mask[2] = (head.rd_we != gold_rd_we_i) ||
                   (head.rd_we && gold_rd_we_i && (head.rd != gold_rd_i));
  assign mask[3] = head.rd_we && gold_rd_we_i && (head.rd != '0) &&
                   (head.rd_data != gold_rd_data_i);
  assign end_hit = pop && (gold_pc_i == END_PC) && (mask == 4'b0000);

  assign finish_o     = (state == S_DRAIN);
  assign done_o       = (state == S_DONE);
  assign fifo_count_o = count;
  assign state_o      = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i)    state_nxt = S_RUN;
      S_RUN:   if (end_hit)    state_nxt = S_DRAIN;
      S_DRAIN: if (mem_done_i) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Storage is not reset; the pointers and occupancy define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{cpu_pc_i, cpu_instr_i, cpu_rd_we_i, cpu_rd_i, cpu_rd_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      error_o      <= 1'b0;
      overflow_o   <= 1'b0;
      err_pc_o     <= '0;
      err_mask_o   <= '0;
      cycles_o     <= '0;
      commits_o    <= '0;
      mismatches_o <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) begin
        overflow_o <= 1'b1;
        error_o    <= 1'b1;
      end
      if ((state == S_RUN || state == S_DRAIN) && cycles_o != '1)
        cycles_o <= cycles_o + 1'b1;
      if (pop) begin
        if (commits_o != '1) commits_o <= commits_o + 1'b1;
        if (mask != 4'b0000) begin
          error_o <= 1'b1;
          if (mismatches_o != '1) mismatches_o <= mismatches_o + 1'b1;
          // Mismatch count only leaves zero once, so it marks the first divergence.
          if (mismatches_o == '0) begin
            err_pc_o   <= head.pc;
            err_mask_o <= mask;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_commit_stream_checker.sv
// Bench for commit_stream_checker: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a queue-based reference model.
module tb_commit_stream_checker;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] END_PC = 32'h58;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_i, start_i, cpu_commit_i, cpu_rd_we_i, gold_valid_i, gold_rd_we_i, mem_done_i;
  logic [31:0] cpu_pc_i, cpu_instr_i, cpu_rd_data_i, gold_pc_i, gold_instr_i, gold_rd_data_i;
  logic [4:0]  cpu_rd_i, gold_rd_i;
  logic        gold_ready_o, finish_o, done_o, error_o, overflow_o;
  logic [31:0] err_pc_o, cycles_o, commits_o, mismatches_o;
  logic [3:0]  err_mask_o;
  logic [2:0]  fifo_count_o;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  commit_stream_checker #(.FIFO_DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .cpu_commit_i(cpu_commit_i), .cpu_pc_i(cpu_pc_i), .cpu_instr_i(cpu_instr_i),
    .cpu_rd_we_i(cpu_rd_we_i), .cpu_rd_i(cpu_rd_i), .cpu_rd_data_i(cpu_rd_data_i),
    .gold_valid_i(gold_valid_i), .gold_pc_i(gold_pc_i), .gold_instr_i(gold_instr_i),
    .gold_rd_we_i(gold_rd_we_i), .gold_rd_i(gold_rd_i), .gold_rd_data_i(gold_rd_data_i),
    .gold_ready_o(gold_ready_o), .finish_o(finish_o), .mem_done_i(mem_done_i),
    .done_o(done_o), .error_o(error_o), .overflow_o(overflow_o),
    .err_pc_o(err_pc_o), .err_mask_o(err_mask_o), .cycles_o(cycles_o),
    .commits_o(commits_o), .mismatches_o(mismatches_o), .fifo_count_o(fifo_count_o),
    .state_o(state_o)
  );

  // Reference model state
  rec_t        m_q[$];
  int          m_phase;
  logic [31:0] m_cycles, m_commits, m_mism, m_err_pc;
  logic [3:0]  m_err_mask;
  logic        m_error, m_ovf, m_pop;
  int          checks = 0;
  int          fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

  function automatic logic [3:0] diff_mask(input rec_t c, input rec_t g);
    logic [3:0] m;
    m[0] = c.pc != g.pc;
    m[1] = c.instr != g.instr;
    m[2] = (c.we != g.we) || (c.we && g.we && c.rd != g.rd);
    m[3] = c.we && g.we && (c.rd != 5'd0) && (c.data != g.data);
    return m;
  endfunction

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                              input logic [4:0] rd, input logic [31:0] data);
    rec_t r;
    r.pc = pc; r.instr = instr; r.we = we; r.rd = rd; r.data = data;
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_phase = P_IDLE;
    m_cycles = 0; m_commits = 0; m_mism = 0; m_err_pc = 0; m_err_mask = 0;
    m_error = 0; m_ovf = 0; m_pop = 0;
  endtask

  task automatic model_update();
    rec_t c, g, n;
    logic [3:0] mk4;
    logic end_now;
    end_now = 0;
    m_pop = 0;
    if (rst_i) model_reset();
    else begin
      g = mk(gold_pc_i, gold_instr_i, gold_rd_we_i, gold_rd_i, gold_rd_data_i);
      n = mk(cpu_pc_i, cpu_instr_i, cpu_rd_we_i, cpu_rd_i, cpu_rd_data_i);
      if (m_phase == P_RUN && gold_valid_i && m_q.size() > 0) begin
        m_pop = 1;
        c = m_q.pop_front();
        mk4 = diff_mask(c, g);
        m_commits = sat_inc(m_commits);
        if (mk4 != 0) begin
          if (m_mism == 0) begin m_err_pc = c.pc; m_err_mask = mk4; end
          m_mism = sat_inc(m_mism);
          m_error = 1;
        end else if (g.pc == END_PC) end_now = 1;
      end
      if (m_phase == P_RUN && cpu_commit_i) begin
        if (m_q.size() < DEPTH) m_q.push_back(n);
        else begin m_ovf = 1; m_error = 1; end
      end
      if (m_phase == P_RUN || m_phase == P_DRAIN) m_cycles = sat_inc(m_cycles);
      case (m_phase)
        P_IDLE:  if (start_i)    m_phase = P_RUN;
        P_RUN:   if (end_now)    m_phase = P_DRAIN;
        P_DRAIN: if (mem_done_i) m_phase = P_DONE;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check_eq("gold_ready", gold_ready_o, (m_phase == P_RUN) && (m_q.size() > 0));
    check_eq("finish", finish_o, m_phase == P_DRAIN);
    check_eq("done", done_o, m_phase == P_DONE);
    check_eq("error", error_o, m_error);
    check_eq("overflow", overflow_o, m_ovf);
    check_eq("fifo_count", fifo_count_o, m_q.size());
    check_eq("cycles", cycles_o, m_cycles);
    check_eq("commits", commits_o, m_commits);
    check_eq("mismatches", mismatches_o, m_mism);
    check_eq("err_pc", err_pc_o, m_err_pc);
    check_eq("err_mask", err_mask_o, m_err_mask);
  endtask

  // Called right after a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst_i = 0; start_i = 0; cpu_commit_i = 0; gold_valid_i = 0; mem_done_i = 0;
  endtask

  task automatic set_cpu(input rec_t r);
    cpu_commit_i = 1;
    cpu_pc_i = r.pc; cpu_instr_i = r.instr; cpu_rd_we_i = r.we; cpu_rd_i = r.rd; cpu_rd_data_i = r.data;
  endtask

  task automatic set_gold(input rec_t r);
    gold_valid_i = 1;
    gold_pc_i = r.pc; gold_instr_i = r.instr; gold_rd_we_i = r.we; gold_rd_i = r.rd; gold_rd_data_i = r.data;
  endtask

  task automatic do_reset();
    idle_inputs(); rst_i = 1; tick(); rst_i = 0;
  endtask

  task automatic do_start();
    idle_inputs(); start_i = 1; tick(); start_i = 0;
  endtask

  rec_t recs[5];
  logic [31:0] saved_cycles;

  initial begin
    idle_inputs();
    rst_i = 1;
    {cpu_pc_i, cpu_instr_i, cpu_rd_we_i, cpu_rd_i, cpu_rd_data_i} = '0;
    {gold_pc_i, gold_instr_i, gold_rd_we_i, gold_rd_i, gold_rd_data_i} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_i = 0;
    #1;
    check_eq("rst_error", error_o, 1'b0);
    check_eq("rst_count", fifo_count_o, 3'd0);
    check_eq("rst_ready", gold_ready_o, 1'b0);

    // T1: three identical commits
    do_start();
    for (int i = 0; i < 3; i++) recs[i] = mk(32'h1000 + 32'(4 * i), 32'h13 + 32'(i), 1'b1, 5'(i + 1), 32'(i));
    idle_inputs(); set_cpu(recs[0]); tick();
    idle_inputs(); set_cpu(recs[1]); tick();
    idle_inputs(); set_cpu(recs[2]); set_gold(recs[0]); tick();
    idle_inputs(); set_gold(recs[1]); tick();
    idle_inputs(); set_gold(recs[2]); tick();
    idle_inputs(); tick();
    check_eq("t1_commits", commits_o, 32'd3);
    check_eq("t1_mism", mismatches_o, 32'd0);
    check_eq("t1_error", error_o, 1'b0);

    // T2: rd_data divergence on addi x2
    idle_inputs(); set_cpu(mk(32'h1004, 32'h0050_0113, 1'b1, 5'd2, 32'h5)); tick();
    idle_inputs(); set_gold(mk(32'h1004, 32'h0050_0113, 1'b1, 5'd2, 32'h6)); tick();
    check_eq("t2_error", error_o, 1'b1);
    check_eq("t2_err_pc", err_pc_o, 32'h1004);
    check_eq("t2_mask", err_mask_o, 4'b1000);
    check_eq("t2_mism", mismatches_o, 32'd1);
    idle_inputs(); tick();

    // T3: overflow on fifth commit, four survivors pop intact
    do_reset(); do_start();
    for (int i = 0; i < 5; i++) begin
      recs[i] = mk(32'h2000 + 32'(4 * i), $urandom, 1'b1, 5'(i + 3), $urandom);
      idle_inputs(); set_cpu(recs[i]); tick();
    end
    idle_inputs();
    check_eq("t3_count", fifo_count_o, 3'd4);
    check_eq("t3_ovf", overflow_o, 1'b1);
    for (int i = 0; i < 4; i++) begin idle_inputs(); set_gold(recs[i]); tick(); end
    idle_inputs(); tick();
    check_eq("t3_commits", commits_o, 32'd4);
    check_eq("t3_mism", mismatches_o, 32'd0);

    // T4: push and pop together while full
    do_reset(); do_start();
    for (int i = 0; i < 4; i++) begin
      recs[i] = mk(32'h3000 + 32'(4 * i), $urandom, 1'b0, 5'd0, 32'd0);
      idle_inputs(); set_cpu(recs[i]); tick();
    end
    recs[4] = mk(32'h3010, $urandom, 1'b0, 5'd0, 32'd0);
    idle_inputs(); set_cpu(recs[4]); set_gold(recs[0]); tick();
    check_eq("t4_ovf", overflow_o, 1'b0);
    check_eq("t4_count", fifo_count_o, 3'd4);

    // T6: mismatch then reset with three entries buffered
    idle_inputs(); set_gold(mk(32'h9999, 32'd0, 1'b0, 5'd0, 32'd0)); tick();
    check_eq("t6_pre_count", fifo_count_o, 3'd3);
    check_eq("t6_pre_error", error_o, 1'b1);
    do_reset(); idle_inputs(); #1;
    check_eq("t6_count", fifo_count_o, 3'd0);
    check_eq("t6_cycles", cycles_o, 32'd0);
    check_eq("t6_commits", commits_o, 32'd0);
    check_eq("t6_error", error_o, 1'b0);
    check_eq("t6_ready", gold_ready_o, 1'b0);

    // T5: matching END_PC commit, finish/done handshake
    do_start();
    recs[0] = mk(END_PC, 32'h0000_006f, 1'b0, 5'd0, 32'd0);
    idle_inputs(); set_cpu(recs[0]); tick();
    idle_inputs(); set_gold(recs[0]); tick();
    check_eq("t5_finish", finish_o, 1'b1);
    check_eq("t5_done_early", done_o, 1'b0);
    for (int i = 0; i < 2; i++) begin idle_inputs(); set_cpu(mk(32'h5c, 32'd1, 1'b0, 5'd0, 32'd0)); tick(); end
    idle_inputs(); mem_done_i = 1; tick();
    saved_cycles = m_cycles;
    for (int i = 0; i < 3; i++) begin idle_inputs(); set_cpu(mk(32'h60, 32'd2, 1'b0, 5'd0, 32'd0)); tick(); end
    check_eq("t5_done", done_o, 1'b1);
    check_eq("t5_finish_off", finish_o, 1'b0);
    check_eq("t5_count", fifo_count_o, 3'd0);
    check_eq("t5_cycles", cycles_o, saved_cycles);
    check_eq("t5_commits", commits_o, 32'd1);

    // Randomized traffic; golden driver mostly mirrors the model's head, sometimes corrupted
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rec_t r, g;
      idle_inputs();
      rst_i   = ($urandom_range(0, 599) == 0);
      start_i = (m_phase == P_IDLE) && ($urandom_range(0, 3) == 0);
      r = mk(32'h4000 + 32'(4 * n), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 45) set_cpu(r);
      if (m_q.size() > 0 && $urandom_range(0, 99) < 55) begin
        g = m_q[0];
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 4))
            0: g.pc    = g.pc ^ 32'h4;
            1: g.instr = g.instr ^ 32'h1;
            2: g.we    = ~g.we;
            3: g.rd    = g.rd ^ 5'h1;
            default: g.data = g.data ^ 32'h1;
          endcase
        end
        set_gold(g);
      end else if ($urandom_range(0, 9) == 0) begin
        set_gold(mk($urandom, $urandom, 1'b1, 5'd1, $urandom));
      end
      tick();
    end
    idle_inputs(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
